// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one 32-bit add/sub unit between NREQ requesters
// Optional ADDER_ARB_STATS_EN adds per-requester grant counters and a response stall counter.
module adder_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_result,
  output logic              resp_zero,
  output logic              resp_overflow,
  output logic              resp_carry
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [32*NREQ-1:0] stat_grants,
  output logic [31:0]        stat_stall
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [31:0]    op_a, op_b, op_bx;
  logic           op_sub;
  logic [32:0]    sum;
  logic           can_accept, accept;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin : arbitrate
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    op_a    = '0;
    op_b    = '0;
    op_sub  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
        op_a    = req_a[32*j +: 32];
        op_b    = req_b[32*j +: 32];
        op_sub  = req_op[j];
      end
    end
  end

  assign can_accept = rst_n && ((state == EMPTY) || resp_ready);
  assign accept     = gnt_any && can_accept;
  assign req_ready  = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign resp_valid = (state == FULL);

  assign op_bx = op_b ^ {32{op_sub}};
  assign sum   = {1'b0, op_a} + {1'b0, op_bx} + {32'b0, op_sub};

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = FULL;
    else if (state == FULL && resp_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Data outputs only change on a new grant; a plain drain leaves them holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      resp_id       <= '0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_carry    <= 1'b0;
    end else if (accept) begin
      rr_ptr        <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      resp_id       <= gnt_idx;
      resp_result   <= sum[31:0];
      resp_zero     <= ~|sum[31:0];
      resp_overflow <= (op_a[31] == op_bx[31]) && (sum[31] != op_a[31]);
      resp_carry    <= sum[32];
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] grant_cnt [NREQ];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (accept && gnt_idx == IDW'(i)) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      if (state == FULL && !resp_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_grants[32*g +: 32] = grant_cnt[g];
  end
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized self-checking bench for adder_arbiter against a behavioural model
// Stats ports are exercised when ADDER_ARB_STATS_EN is defined.
module tb_adder_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_op = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_result;
  logic              resp_zero, resp_overflow, resp_carry;
`ifdef ADDER_ARB_STATS_EN
  logic [32*NREQ-1:0] stat_grants;
  logic [31:0]        stat_stall;
`endif

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_overflow(resp_overflow), .resp_carry(resp_carry)
`ifdef ADDER_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side operand registers and the behavioural model state.
  logic [31:0] ta [NREQ];
  logic [31:0] tb_ [NREQ];
  logic        top [NREQ];
  int          m_ptr, m_id, last_g;
  bit          m_full;
  logic [31:0] m_res;
  bit          m_z, m_o, m_c;
  int unsigned m_cnt [NREQ];
  int unsigned m_stall;

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 output logic [31:0] r, output bit z, output bit o, output bit c);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = op ? sa - sb : sa + sb;
    r  = op ? a - b : a + b;
    z  = (r == 32'd0);
    o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    c  = op ? (a >= b) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_id = 0; m_res = '0; m_z = 0; m_o = 0; m_c = 0;
    m_stall = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int g;
    bit can, was_full;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = ta[i];
      req_b[32*i +: 32] = tb_[i];
      req_op[i]         = top[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    can = !m_full || rr;
    exp_rdy = (g >= 0 && can) ? NREQ'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("resp_valid", 64'(resp_valid), 64'(m_full));
    check("resp_id", 64'(resp_id), 64'(m_id));
    check("resp_result", 64'(resp_result), 64'(m_res));
    check("resp_flags", {61'd0, resp_zero, resp_overflow, resp_carry}, {61'd0, m_z, m_o, m_c});
`ifdef ADDER_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) check("stat_grants", 64'(stat_grants[32*i +: 32]), 64'(m_cnt[i]));
    check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    was_full = m_full;
    if (g >= 0 && can) begin
      ref_op(ta[g], tb_[g], top[g], m_res, m_z, m_o, m_c);
      m_id = g; m_full = 1; m_ptr = (g + 1) % NREQ; m_cnt[g]++;
      last_g = g;
    end else begin
      last_g = -1;
      if (m_full && rr) m_full = 0;
    end
    if (was_full && !rr) m_stall++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp", {resp_id, resp_result, resp_zero, resp_overflow, resp_carry}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    ta[i] = a; tb_[i] = b; top[i] = op;
  endtask

  task automatic expect_resp(input string tag, input int id, input logic [31:0] r,
                             input bit z, input bit o, input bit c);
    check({tag, "_valid"}, 64'(resp_valid), 64'd1);
    check({tag, "_id"}, 64'(resp_id), 64'(id));
    check({tag, "_result"}, 64'(resp_result), 64'(r));
    check({tag, "_zoc"}, {61'd0, resp_zero, resp_overflow, resp_carry}, {61'd0, z, o, c});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] rv;
    for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, 1'b0);
    do_reset();

    set_op(0, 32'd5, 32'd3, 1'b0);
    step(3'b001, 1'b1);
    check("single_ready", 64'(last_g), 64'd0);
    step(3'b000, 1'b1);
    expect_resp("add_5_3", 0, 32'd8, 0, 0, 0);

    set_op(1, 32'd5, 32'd5, 1'b1);
    step(3'b010, 1'b1);
    step(3'b000, 1'b1);
    expect_resp("sub_eq", 1, 32'd0, 1, 0, 1);
    set_op(1, 32'h8000_0000, 32'd1, 1'b1);
    step(3'b010, 1'b1);
    step(3'b000, 1'b1);
    expect_resp("sub_ovf", 1, 32'h7FFF_FFFF, 0, 1, 1);

    set_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    step(3'b001, 1'b1);
    step(3'b000, 1'b1);
    expect_resp("add_ovf", 0, 32'h8000_0000, 0, 1, 0);
    set_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step(3'b001, 1'b1);
    step(3'b000, 1'b1);
    expect_resp("add_carry", 0, 32'd0, 1, 0, 1);

    // Round-robin with every requester asking continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 16), 32'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 1'b1);
      check("rr_grant", 64'(last_g), 64'(k % NREQ));
      if (k > 0) check("rr_resp_id", 64'(resp_id), 64'((k - 1) % NREQ));
    end

    // Buffer holds id 2; stall while requester 0 waits.
    for (int k = 0; k < 4; k++) begin
      step(3'b001, 1'b0);
      check("stall_id", 64'(resp_id), 64'd2);
      check("stall_result", 64'(resp_result), 64'd33);
    end
    step(3'b001, 1'b1);
    check("stall_release_grant", 64'(last_g), 64'd0);
    step(3'b000, 1'b0);
    check("stall_release_id", 64'(resp_id), 64'd0);

    // Asynchronous reset between edges while FULL and stalled.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(resp_valid), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    model_reset();
`ifdef ADDER_ARB_STATS_EN
    check("async_rst_stats", 64'(stat_grants[31:0] | stat_grants[63:32] | stat_grants[95:64] | stat_stall), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b101, 1'b1);
    check("post_rst_grant", 64'(last_g), 64'd0);

    // Random traffic: a requester holds its request until the model says it was accepted.
    rv = 3'b100;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(0, 2) != 0) begin
          rv[i] = 1'b1;
          set_op(i, pick(), pick(), 1'($urandom_range(0, 1)));
        end
      step(rv, $urandom_range(0, 3) != 0);
      if (last_g >= 0) rv[last_g] = 1'b0;
    end

    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Shares one 32-bit add/subtract unit between NREQ requesters, such as the PC incrementer, the EXU ALU path and the LSU address generator. Arbitration is round-robin with valid/ready handshakes on each request and on the single response channel. The result is registered in a one-entry output buffer, so latency is 1 cycle with full throughput under no backpressure. It sits between the requesting units and the shared adder datapath in the NPC core.

Parameters:
NREQ, 3, number of requesters (2..8)
IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester grant/accept (one-hot or zero)
req_a  input  32*NREQ  operand A, requester i at bits [32i+31:32i]
req_b  input  32*NREQ  operand B, same packing
req_op  input  NREQ  0 = A+B, 1 = A-B
resp_valid  output  1  response buffer holds a result
resp_ready  input  1  consumer accepts response
resp_id  output  IDW  index of requester that produced the result
resp_result  output  32  sum/difference
resp_zero  output  1  result == 0
resp_overflow  output  1  signed 32-bit overflow
resp_carry  output  1  carry-out of bit 31 (for subtract: 1 = no borrow)

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_overflow=0, resp_carry=0, RR pointer=0, buffer state EMPTY. req_ready is combinational and 0 while in reset.
- Arithmetic: Bx = B XOR {32{op}}, {carry,result} = A + Bx + op (33-bit). overflow = (A[31]==Bx[31]) && (result[31]!=A[31]). zero = ~|result.
- Buffer states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
- can_accept = EMPTY || (FULL && resp_ready).
- Arbitration is combinational. Search req_valid starting at the RR pointer, wrapping modulo NREQ. The first valid index g is granted. req_ready[g] = can_accept, all other req_ready bits are 0. Requesters never see more than one ready bit high.
- On a clock edge where req_valid[g] && req_ready[g]:
  - operands for requester g are computed and loaded into the buffer;
  - resp_id = g, the state becomes FULL;
  - RR pointer = (g+1) mod NREQ.
- FULL && resp_ready with no new grant: the state becomes EMPTY. Data outputs hold their last value, and the RR pointer is unchanged.
- FULL && !resp_ready: all response outputs hold stable, req_ready=0, and the RR pointer is unchanged.
- Simultaneous drain and accept in FULL: the new result replaces the old one in the same edge and resp_valid stays 1. This sustains one op per cycle.
- No request valid: the RR pointer does not move.
- Requesters must hold valid and operands stable until accepted. The arbiter must not drop or duplicate a request.
- Reset asserted mid-operation: the buffered result is discarded, and after release the first grant starts from index 0.
- Wrap-around: with all requesters valid continuously, grants go 0,1,…,NREQ-1,0,…

Optional Feature:
ADDER_ARB_STATS_EN.
- When defined, the block adds output stat_grants (32*NREQ), one 32-bit counter per requester.
  - Each counter increments on every accepted request from that requester.
  - Counters wrap from 0xFFFFFFFF to 0 and reset to 0 on rst_n.
- Also adds output stat_stall (32), which increments every cycle with resp_valid && !resp_ready and also wraps.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset then single request: req0 A=0x00000005, B=0x00000003, op=0, resp_ready=1.
  -> req_ready[0] is high the same cycle. Next cycle: resp_valid=1, id=0, result=0x00000008, carry=0, overflow=0, zero=0.
- Subtract edge cases: req1 A=5, B=5, op=1 -> result=0, zero=1, carry=1. Then A=0x80000000, B=1, op=1 -> result=0x7FFFFFFF, overflow=1, carry=1.
- Overflow and carry on add: A=0x7FFFFFFF, B=1, op=0 -> result=0x80000000, overflow=1, carry=0. Then A=0xFFFFFFFF, B=1 -> result=0, carry=1, zero=1.
- Round-robin fairness: all three req_valid held high for 6 cycles with resp_ready=1.
  -> grants and resp_ids follow 0,1,2,0,1,2, resp_valid stays high every cycle, and no request is lost.
- Backpressure: buffer FULL (id=2), resp_ready=0 for 4 cycles while req0 is valid.
  -> req_ready=0 and outputs stable during the stall. When resp_ready=1, req0 is accepted that edge and the next response has id=0.
- Async reset mid-stall: assert rst_n=0 between clock edges while FULL.
  -> resp_valid drops immediately. After release with req2 and req0 valid, req0 is granted first (pointer=0). With ADDER_ARB_STATS_EN, all counters read 0.
